spislave_io: RTL and testbench
==============================

# spislave_io

SPI slave peripheral for the 68HC11-style system bus: the responder end of the SPI link driven by the board's SPI master block. An external master clocks bytes in on mosi while the slave shifts bytes out on miso. The CPU sees a byte-wide register file with receive/transmit holding registers, status flags and an interrupt, using the same select/strobe scheme as the other bus peripherals. All SPI pins are oversampled in the system clock domain; mode 0 only (CPOL=0, CPHA=0), MSB first.

## Interface
- DUMMY_RESET, 8'hFF, reset value of the DUMMY register
- SYNC_STAGES, 2, synchronizer depth on sck/mosi/ss (≥2)
- clk  in  1  system clock; all state on posedge
- rst  in  1  asynchronous, active-low reset (mainboard drives it from its active-high reset, inverted)
- AD  in  3  register select, AD[1:0] decoded, AD[2] ignored
- DI  in  8  write data from CPU
- DO  out  8  read data, combinational from AD
- rw  in  1  1=read, 0=write
- cs  in  1  select, already qualified with vma; one-cycle access
- irq  out  1  level interrupt, registered
- sck  in  1  SPI clock from master
- mosi  in  1  serial data in
- ss  in  1  slave select, active-low
- miso  out  1  serial data out
- miso_oe  out  1  miso output enable (1 only while selected and EN=1)

## Operation
- Registers:
  - 0 DATA: read returns RXBUF and clears RXF; write loads TXBUF and clears TXE.
  - 1 STATUS: bit0 RXF, bit1 TXE, bit2 OVR, bit3 SEL (synced ss active), bit7 BUSY (bit counter ≠ 0); others 0. Writing 1 to bit2 clears OVR; other bits read-only.
  - 2 CTRL: bit0 EN, bit1 RXIE, bit2 TXIE, rest 0.
  - 3 DUMMY: byte sent when TXBUF is empty at load time.
- Reset values: RXBUF 0, TXBUF 0, RXF 0, TXE 1, OVR 0, CTRL 0, DUMMY DUMMY_RESET, shift registers 0, bit counter 0, irq 0, miso 0, miso_oe 0.
- EN=0: SPI edges are ignored, the counter is held at 0, and miso_oe=0. Registers remain accessible.
- Frame start (synced ss falling, EN=1): load TX shift register from TXBUF if TXE=0 (then TXE←1), else from DUMMY. miso←shift[7]. Counter←0.
- sck rising (synced): shift in mosi and increment the 3-bit counter.
- sck falling: shift TX left; miso←next bit.
- 8th rising edge completes a byte:
  - If RXF=0: RXBUF←shift, RXF←1.
  - If RXF=1: the byte is discarded and OVR←1.
  - The next TX byte is loaded as at frame start, so back-to-back bytes need no ss toggle.
- ss rising mid-byte: the partial byte is discarded, the counter is cleared, miso_oe←0, and flags are untouched.
- irq = EN & ((RXIE & RXF) | (TXIE & TXE) | (RXIE & OVR)), registered.
- Simultaneous events:
  - CPU read of DATA in the same cycle as byte completion: RXF ends at 1, RXBUF holds the new byte, and no OVR is raised.
  - CPU write of DATA in the same cycle as a TX load: the load takes the old TXBUF/DUMMY and TXE ends at 0 (new byte queued).

## Timing
- Synchronizer delay is SYNC_STAGES clk, plus 1 clk for edge detection.
- RXF rises 1 clk after the detected 8th rising edge.
- irq follows flags by 1 clk.
- miso updates 1 clk after the detected falling edge.
- sck frequency ≤ clk/8; the master must hold ss low ≥4 clk before the first sck rising edge.
- Bus side: writes take effect at the clk edge where cs=1 and rw=0. Read side effects occur at the edge where cs=1 and rw=1; DO is valid in that same cycle.

## Structure
- Shared package holds the register offsets (DATA/STATUS/CTRL/DUMMY) and the STATUS/CTRL bit positions, so software headers and the bench agree.
- One sub-module, spislave_sync: a parameterized N-stage synchronizer with rise/fall pulse outputs. It is instantiated for sck and ss; mosi uses the same module without the edge outputs.
- The top level holds the register file, both shift registers, the counter and irq logic.

## Test plan
- Reset with rst=0 mid-frame → STATUS reads 8'h02, CTRL reads 0, DUMMY reads 8'hFF, irq=0, miso_oe=0.
- EN=1, TXBUF←8'hA5; master sends 8'h3C in one frame → master receives 8'hA5; DATA reads 8'h3C; RXF clears after the read; TXE=1.
- TXBUF left empty, DUMMY←8'h5A; 3-byte burst without ss toggle → master receives 5A,5A,5A; unread bytes after the first set OVR; RXBUF holds the first byte.
- RXIE=1; receive one byte → irq rises 1 clk after RXF and falls 1 clk after the DATA read.
- ss deasserted after 5 bits → BUSY clears, RXF stays 0, miso_oe=0; the next full frame is received correctly.
- DATA read coincident with byte completion → RXF=1, OVR=0, and the second DATA read returns the new byte.

Source files
------------

// File: rtl/spislave_io_pkg.sv
// Shared register map and bit positions for the SPI slave peripheral.
// No logic, so no latency; bus accesses are single-cycle with no stall.
package spislave_io_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DUMMY  = 2'd3;

    localparam int ST_RXF  = 0;
    localparam int ST_TXE  = 1;
    localparam int ST_OVR  = 2;
    localparam int ST_SEL  = 3;
    localparam int ST_BUSY = 7;

    localparam int CT_EN   = 0;
    localparam int CT_RXIE = 1;
    localparam int CT_TXIE = 2;

endpackage

// File: rtl/spislave_sync.sv
// N-stage synchronizer with registered single-cycle rise/fall pulses.
// q lags d by STAGES clk, pulses by one more; no backpressure.
module spislave_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
            fall  <= ~chain[STAGES-1] & prev;
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spislave_io.sv
// SPI mode-0 slave with CPU register file (DATA/STATUS/CTRL/DUMMY) and level irq.
// Pins see SYNC_STAGES+1 clk of detection delay; the CPU bus never stalls.
module spislave_io
    import spislave_io_pkg::*;
#(
    parameter logic [7:0] DUMMY_RESET = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       sck,
    input  logic       mosi,
    input  logic       ss,
    output logic       miso,
    output logic       miso_oe
);

    logic       sck_rise, sck_fall, sck_lvl_unused;
    logic       ss_q, ss_fall, ss_rise_unused;
    logic       mosi_q;
    logic [1:0] mosi_edges_unused;
    logic       ad_unused;

    spislave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .d(sck), .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));
    spislave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .d(ss), .q(ss_q), .rise(ss_rise_unused), .fall(ss_fall));
    spislave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_q),
        .rise(mosi_edges_unused[0]), .fall(mosi_edges_unused[1]));

    assign ad_unused = AD[2];

    logic       en, rxie, txie, rxf, txe, ovr;
    logic [7:0] rxbuf, txbuf, dummy, rx_sh, tx_sh;
    logic [2:0] cnt;

    logic       sel, frame_start, sck_rise_v, sck_fall_v, byte_done, tx_load;
    logic       data_rd, data_wr, st_wr, ctrl_wr, dummy_wr;
    logic [7:0] tx_next, rx_next;

    assign sel         = ~ss_q;
    assign frame_start = en & ss_fall;
    assign sck_rise_v  = en & sel & sck_rise;
    assign sck_fall_v  = en & sel & sck_fall;
    assign byte_done   = sck_rise_v & (cnt == 3'd7);
    assign tx_load     = frame_start | byte_done;
    assign tx_next     = txe ? dummy : txbuf;
    assign rx_next     = {rx_sh[6:0], mosi_q};

    assign data_rd  = cs &  rw & (AD[1:0] == REG_DATA);
    assign data_wr  = cs & ~rw & (AD[1:0] == REG_DATA);
    assign st_wr    = cs & ~rw & (AD[1:0] == REG_STATUS);
    assign ctrl_wr  = cs & ~rw & (AD[1:0] == REG_CTRL);
    assign dummy_wr = cs & ~rw & (AD[1:0] == REG_DUMMY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en      <= 1'b0;
            rxie    <= 1'b0;
            txie    <= 1'b0;
            rxf     <= 1'b0;
            txe     <= 1'b1;
            ovr     <= 1'b0;
            rxbuf   <= 8'h00;
            txbuf   <= 8'h00;
            dummy   <= DUMMY_RESET;
            rx_sh   <= 8'h00;
            tx_sh   <= 8'h00;
            cnt     <= 3'd0;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            irq     <= 1'b0;
        end else begin
            // A CPU write in the same cycle as a load still queues its byte.
            if (data_wr) begin
                txbuf <= DI;
                txe   <= 1'b0;
            end else if (tx_load && !txe) begin
                txe <= 1'b1;
            end

            if (ctrl_wr) {txie, rxie, en} <= DI[2:0];
            if (dummy_wr) dummy <= DI;

            if (byte_done && (!rxf || data_rd)) begin
                rxbuf <= rx_next;
                rxf   <= 1'b1;
            end else if (data_rd) begin
                rxf <= 1'b0;
            end

            if (byte_done && rxf && !data_rd) ovr <= 1'b1;
            else if (st_wr && DI[ST_OVR]) ovr <= 1'b0;

            if (!en || !sel || frame_start) cnt <= 3'd0;
            else if (sck_rise_v) cnt <= cnt + 3'd1;

            if (sck_rise_v) rx_sh <= rx_next;

            // The falling edge right after a byte boundary must keep the freshly loaded MSB.
            if (tx_load) begin
                tx_sh <= tx_next;
                miso  <= tx_next[7];
            end else if (sck_fall_v && cnt != 3'd0) begin
                tx_sh <= {tx_sh[6:0], 1'b0};
                miso  <= tx_sh[6];
            end

            miso_oe <= en & sel;
            irq     <= en & ((rxie & rxf) | (txie & txe) | (rxie & ovr));
        end
    end

    always_comb begin
        DO = 8'h00;
        case (AD[1:0])
            REG_DATA:   DO = rxbuf;
            REG_STATUS: DO = {(cnt != 3'd0), 3'b000, sel, ovr, txe, rxf};
            REG_CTRL:   DO = {5'b00000, txie, rxie, en};
            default:    DO = dummy;
        endcase
    end

endmodule

// File: tb/tb_spislave_io.sv
// Directed bench for spislave_io: register table plus hand-written SPI frame sequences.
module tb_spislave_io;
    import spislave_io_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw, cs, irq, sck, mosi, ss, miso, miso_oe;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] coinc_dat;

    spislave_io #(.DUMMY_RESET(8'hFF), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs), .irq(irq),
        .sck(sck), .mosi(mosi), .ss(ss), .miso(miso), .miso_oe(miso_oe));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra;
        logic [7:0] exp;
    } reg_vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; AD = a;
        #1 d = DO;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic ss_low();
        ss = 1'b0;
        tick(6);
    endtask

    task automatic ss_high();
        ss = 1'b1;
        tick(6);
    endtask

    // Mode-0 master, sck period 10 clk; optional DATA read lands on the cycle the byte completes.
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit coinc, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            tick(5);
            rx[7-i] = miso;
            sck = 1'b1;
            if (coinc && i == nbits - 1) begin
                tick(3);
                cs = 1'b1; rw = 1'b1; AD = {1'b0, REG_DATA};
                #1 coinc_dat = DO;
                tick(1);
                cs = 1'b0;
                tick(1);
            end else begin
                tick(5);
            end
            sck = 1'b0;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reg_vec_t   vecs[7];
        logic [7:0] rd, rxb, rxb2, rxb3;
        bit         got;

        vecs[0] = '{3'b010, 8'hFF, 3'b010, 8'h07};
        vecs[1] = '{3'b010, 8'h00, 3'b010, 8'h00};
        vecs[2] = '{3'b011, 8'h5A, 3'b011, 8'h5A};
        vecs[3] = '{3'b111, 8'hC3, 3'b011, 8'hC3};
        vecs[4] = '{3'b110, 8'h05, 3'b010, 8'h05};
        vecs[5] = '{3'b001, 8'hFF, 3'b001, 8'h02};
        vecs[6] = '{3'b011, 8'hFF, 3'b111, 8'hFF};

        rst = 1'b0; AD = 3'd0; DI = 8'h00; rw = 1'b1; cs = 1'b0;
        sck = 1'b0; mosi = 1'b0; ss = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(2);

        // Reset asserted in the middle of a frame.
        cpu_wr(3'd2, 8'h01);
        cpu_wr(3'd0, 8'hA5);
        ss_low();
        xfer(8'hB7, 3, 1'b0, rxb);
        rst = 1'b0;
        tick(1);
        cpu_rd(3'd1, rd); chk("rst_status", rd, 8'h02);
        cpu_rd(3'd2, rd); chk("rst_ctrl", rd, 8'h00);
        cpu_rd(3'd3, rd); chk("rst_dummy", rd, 8'hFF);
        cpu_rd(3'd0, rd); chk("rst_data", rd, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("rst_miso_oe", {7'b0, miso_oe}, 8'h00);
        chk("rst_miso", {7'b0, miso}, 8'h00);
        ss = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(4);

        for (int i = 0; i < 7; i++) begin
            cpu_wr(vecs[i].wa, vecs[i].wd);
            cpu_rd(vecs[i].ra, rd);
            chk($sformatf("regvec%0d", i), rd, vecs[i].exp);
        end
        cpu_wr(3'd2, 8'h00);

        // Single frame with a queued TX byte.
        cpu_wr(3'd2, 8'h01);
        cpu_wr(3'd0, 8'hA5);
        cpu_rd(3'd1, rd); chk("a_status_txfull", rd, 8'h00);
        ss_low();
        chk("a_miso_oe_on", {7'b0, miso_oe}, 8'h01);
        xfer(8'h3C, 8, 1'b0, rxb);
        chk("a_master_rx", rxb, 8'hA5);
        ss_high();
        chk("a_miso_oe_off", {7'b0, miso_oe}, 8'h00);
        cpu_rd(3'd1, rd); chk("a_status_rx", rd, 8'h03);
        cpu_rd(3'd0, rd); chk("a_data", rd, 8'h3C);
        cpu_rd(3'd1, rd); chk("a_status_after", rd, 8'h02);

        // Three-byte burst from DUMMY, no ss toggle.
        cpu_wr(3'd3, 8'h5A);
        ss_low();
        xfer(8'h11, 8, 1'b0, rxb);
        xfer(8'h22, 8, 1'b0, rxb2);
        xfer(8'h33, 8, 1'b0, rxb3);
        ss_high();
        chk("b_rx0", rxb, 8'h5A);
        chk("b_rx1", rxb2, 8'h5A);
        chk("b_rx2", rxb3, 8'h5A);
        cpu_rd(3'd1, rd); chk("b_status_ovr", rd, 8'h07);
        cpu_rd(3'd0, rd); chk("b_data_first", rd, 8'h11);
        cpu_rd(3'd1, rd); chk("b_status_read", rd, 8'h06);
        cpu_wr(3'd1, 8'h04);
        cpu_rd(3'd1, rd); chk("b_status_clr", rd, 8'h02);

        // RX interrupt timing against RXF, watched through STATUS.
        cpu_wr(3'd2, 8'h03);
        tick(2);
        chk("c_irq_idle", {7'b0, irq}, 8'h00);
        ss_low();
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; AD = 3'd1;
        fork
            xfer(8'h77, 8, 1'b0, rxb);
            begin
                got = 1'b0;
                for (int k = 0; k < 400 && !got; k++) begin
                    @(posedge clk);
                    #1 if (DO[ST_RXF]) got = 1'b1;
                end
                chk("c_rxf_seen", {7'b0, got}, 8'h01);
                chk("c_irq_with_rxf", {7'b0, irq}, 8'h00);
                @(posedge clk);
                #1 chk("c_irq_next", {7'b0, irq}, 8'h01);
            end
        join
        cs = 1'b0;
        ss_high();
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; AD = 3'd0;
        #1 rd = DO;
        @(posedge clk);
        #1 chk("c_irq_at_read", {7'b0, irq}, 8'h01);
        @(negedge clk);
        cs = 1'b0;
        @(posedge clk);
        #1 chk("c_irq_cleared", {7'b0, irq}, 8'h00);
        chk("c_data", rd, 8'h77);

        // Frame aborted after 5 bits, then a full frame.
        ss_low();
        xfer(8'hE9, 5, 1'b0, rxb);
        cpu_rd(3'd1, rd); chk("d_status_busy", rd, 8'h8A);
        ss_high();
        cpu_rd(3'd1, rd); chk("d_status_abort", rd, 8'h02);
        chk("d_miso_oe", {7'b0, miso_oe}, 8'h00);
        cpu_wr(3'd0, 8'h96);
        ss_low();
        xfer(8'hC6, 8, 1'b0, rxb);
        ss_high();
        chk("d_master_rx", rxb, 8'h96);
        cpu_rd(3'd0, rd); chk("d_data", rd, 8'hC6);
        cpu_rd(3'd1, rd); chk("d_status_end", rd, 8'h02);

        // DATA read coinciding with completion of the next byte.
        ss_low();
        xfer(8'h81, 8, 1'b0, rxb);
        xfer(8'h42, 8, 1'b1, rxb2);
        ss_high();
        chk("e_coinc_read", coinc_dat, 8'h81);
        cpu_rd(3'd1, rd); chk("e_status", rd, 8'h03);
        cpu_rd(3'd0, rd); chk("e_data_new", rd, 8'h42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
